timer_irq_source: RTL

//   Memory-mapped countdown timer. It is the interrupt initiator that drives one bit of the CP0 HWInt[5:0] vector.

---
 rtl/timer_irq_source.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/timer_irq_source.sv
// timer_irq_source
//   Memory-mapped countdown timer that drives one CP0 HWInt bit. Software loads
//   PRESET, then sets CTRL.EN. The timer reloads COUNT from PRESET, counts down
//   to zero and raises a pending flag. The pending flag is gated by CTRL.IM to
//   form irq. MODE 01 auto-reloads. Any other MODE behaves as one-shot.
//
//   Register window (word address addr[1:0] == byte address bits [3:2]):
//     0 CTRL   : [0] EN, [2:1] MODE, [3] IM; upper bits read 0
//     1 PRESET : read/write
//     2 COUNT  : read-only
//     3 -      : reads 0, writes ignored
//
// Ports
//   clk    in   1   system clock, all state on posedge
//   reset  in   1   synchronous, active-high
//   addr   in  30   word address [31:2]; only the low two bits are decoded
//   we     in   1   write strobe (already qualified by bridge chip-select)
//   din    in  32   write data
//   dout   out 32   read data, combinational on addr
//   irq    out  1   level interrupt request = pending & IM
module timer_irq_source #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_ctrl;
  logic [3:0]       w_ctrl_nxt;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] w_preset_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_pending;
  logic             w_pending_nxt;

  logic             w_en;
  logic             w_auto;
  logic [1:0]       w_sel;
  logic             w_addr_unused;

  assign w_en   = r_ctrl[0];
  assign w_auto = (r_ctrl[2:1] == 2'b01);
  assign w_sel  = addr[1:0];
  // Upper address bits are decoded by the bridge, not here.
  assign w_addr_unused = ^addr[29:2];

  // Next-state and register updates. The FSM looks only at the registered
  // CTRL/PRESET values; a bus write in the same edge is applied last so it
  // overrides anything the FSM would have done to CTRL or pending.
  always_comb begin
    w_state_nxt   = r_state;
    w_ctrl_nxt    = r_ctrl;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;

    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          // Disable freezes COUNT; re-enable always reloads from PRESET.
          w_state_nxt = ST_IDLE;
        end else if (r_count > CNT_W'(1)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          // COUNT of 1 or 0 both expire here, so PRESET=0 behaves like 1.
          w_count_nxt   = '0;
          w_pending_nxt = 1'b1;
          w_state_nxt   = ST_INT;
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (w_auto) begin
          w_pending_nxt = 1'b0;
        end else begin
          w_ctrl_nxt[0] = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (we) begin
      case (w_sel)
        2'd0: begin
          w_ctrl_nxt    = din[3:0];
          w_pending_nxt = 1'b0;
        end
        2'd1: begin
          w_preset_nxt  = din[CNT_W-1:0];
          w_pending_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    dout = '0;
    case (w_sel)
      2'd0:    dout = {28'd0, r_ctrl};
      2'd1:    dout = 32'(r_preset);
      2'd2:    dout = 32'(r_count);
      default: dout = '0;
    endcase
  end

  assign irq = r_pending & r_ctrl[3];

endmodule
